// File: rtl/pe_buf_drain.sv
// ---------------------------------------------------------------------------
// pe_buf_drain
//   Drains the PE reducer's accumulation buffer after a reduction pass.
//   On i_start it walks all ROWS*CHANNELS entries in index order. Each entry
//   is requantized (round, right shift by SHIFT, unsigned saturate to OUT_W)
//   and streamed over a valid/ready interface tagged with row/channel. It
//   also tracks the largest requantized value and its index for the peak
//   detector.
//
// Ports
//   i_clk       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_start     begin a drain (accepted only while idle)
//   i_buf       accumulation buffer, entry k at i_buf[k]; held stable by
//               upstream from i_start until o_done
//   i_ready     downstream accepts the current sample
//   o_valid     o_data/o_row/o_ch/o_last carry a sample
//   o_data      requantized sample
//   o_row/o_ch  buffer coordinates of the current sample
//   o_last      current sample is the final buffer entry
//   o_busy      drain in progress (streaming or done cycle)
//   o_peak_val  largest requantized value of the last completed drain
//   o_peak_idx  index of that value (earliest index on ties)
//   o_done      one-cycle pulse after the final handshake
// ---------------------------------------------------------------------------
module pe_buf_drain #(
   parameter int ROWS     = 8,
   parameter int CHANNELS = 4,
   parameter int ACC_W    = 36,
   parameter int OUT_W    = 16,
   parameter int SHIFT    = 8,
   localparam int N       = ROWS * CHANNELS,
   localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int IDX_W   = (N > 1) ? $clog2(N) : 1
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_start,
   input  logic [N-1:0][ACC_W-1:0]   i_buf,
   input  logic                      i_ready,
   output logic                      o_valid,
   output logic [OUT_W-1:0]          o_data,
   output logic [ROW_W-1:0]          o_row,
   output logic [CH_W-1:0]           o_ch,
   output logic                      o_last,
   output logic                      o_busy,
   output logic [OUT_W-1:0]          o_peak_val,
   output logic [IDX_W-1:0]          o_peak_idx,
   output logic                      o_done
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OUT  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   // Half-LSB rounding offset; shifting right by one makes it vanish for SHIFT=0.
   localparam logic [ACC_W:0] RND_OFS = ((ACC_W+1)'(1) << SHIFT) >> 1;
   localparam logic [ACC_W:0] SAT_MAX = {{(ACC_W+1-OUT_W){1'b0}}, {OUT_W{1'b1}}};

   // One extra bit so the rounding add cannot wrap at the full-scale entry.
   function automatic logic [ACC_W:0] round_shift(input logic [ACC_W-1:0] e);
      logic [ACC_W:0] sum;
      sum = {1'b0, e} + RND_OFS;
      return sum >> SHIFT;
   endfunction

   function automatic logic [OUT_W-1:0] saturate(input logic [ACC_W:0] r);
      if (r > SAT_MAX) begin
         return '1;
      end
      return r[OUT_W-1:0];
   endfunction

   logic [1:0]       state_r;
   logic [IDX_W-1:0] idx_r;
   logic [OUT_W-1:0] pk_val_r;
   logic [IDX_W-1:0] pk_idx_r;

   logic [IDX_W-1:0] ld_idx_p0;
   logic [OUT_W-1:0] ld_data_p0;
   logic             ld_last_p0;
   logic [OUT_W-1:0] pk_val_nxt;
   logic [IDX_W-1:0] pk_idx_nxt;

   // ---- stage p0: select and requantize the entry to present next ----
   always_comb begin
      ld_idx_p0  = (state_r == IDLE) ? '0 : idx_r + IDX_W'(1);
      ld_data_p0 = saturate(round_shift(i_buf[ld_idx_p0]));
      ld_last_p0 = (ld_idx_p0 == IDX_W'(N - 1));
   end

   // Strict compare keeps the earliest index on ties; the tracker is cleared
   // to 0/0 at start, so entry 0 seeds it.
   always_comb begin
      pk_val_nxt = pk_val_r;
      pk_idx_nxt = pk_idx_r;
      if (o_data > pk_val_r) begin
         pk_val_nxt = o_data;
         pk_idx_nxt = idx_r;
      end
   end

   // ---- stage p1: registered output sample and drain control ----
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r    <= IDLE;
         idx_r      <= '0;
         pk_val_r   <= '0;
         pk_idx_r   <= '0;
         o_valid    <= 1'b0;
         o_data     <= '0;
         o_row      <= '0;
         o_ch       <= '0;
         o_last     <= 1'b0;
         o_peak_val <= '0;
         o_peak_idx <= '0;
         o_done     <= 1'b0;
      end else begin
         o_done <= 1'b0;
         case (state_r)
            IDLE: begin
               if (i_start) begin
                  state_r  <= OUT;
                  idx_r    <= '0;
                  o_row    <= '0;
                  o_ch     <= '0;
                  o_data   <= ld_data_p0;
                  o_last   <= ld_last_p0;
                  o_valid  <= 1'b1;
                  pk_val_r <= '0;
                  pk_idx_r <= '0;
               end
            end
            OUT: begin
               if (o_valid && i_ready) begin
                  pk_val_r <= pk_val_nxt;
                  pk_idx_r <= pk_idx_nxt;
                  if (o_last) begin
                     state_r    <= DONE;
                     o_valid    <= 1'b0;
                     o_last     <= 1'b0;
                     o_done     <= 1'b1;
                     o_peak_val <= pk_val_nxt;
                     o_peak_idx <= pk_idx_nxt;
                  end else begin
                     idx_r  <= ld_idx_p0;
                     o_data <= ld_data_p0;
                     o_last <= ld_last_p0;
                     // Wrapping row/channel counters avoid a divide.
                     if (o_ch == CH_W'(CHANNELS - 1)) begin
                        o_ch  <= '0;
                        o_row <= o_row + ROW_W'(1);
                     end else begin
                        o_ch <= o_ch + CH_W'(1);
                     end
                  end
               end
            end
            DONE: begin
               state_r <= IDLE;
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign o_busy = (state_r != IDLE);

endmodule

// File: tb/tb_pe_buf_drain.sv
module tb_pe_buf_drain;

   localparam int ROWS = 8;
   localparam int CHANNELS = 4;
   localparam int ACC_W = 36;
   localparam int OUT_W = 16;
   localparam int SHIFT = 8;
   localparam int N = ROWS * CHANNELS;
   localparam longint OMAX = (longint'(1) << OUT_W) - 1;

   logic clk;
   logic rst_n;
   logic start;
   logic ready;
   logic ready0;
   logic [N-1:0][ACC_W-1:0] buf_v;
   logic [N-1:0][ACC_W-1:0] buf0;

   logic valid, last, busy, done;
   logic [OUT_W-1:0] data, pk_val;
   logic [2:0] row;
   logic [1:0] ch;
   logic [4:0] pk_idx;

   logic valid0, last0, busy0, done0;
   logic [OUT_W-1:0] data0, pkv0;
   logic [2:0] row0;
   logic [1:0] ch0;
   logic [4:0] pki0;

   int n_tests = 0;
   int n_fail = 0;

   // Literal expectations selected by the stimulus per drain.
   int lit_mode = 0;
   int lit_vcyc = 32;

   pe_buf_drain #(.ROWS(ROWS), .CHANNELS(CHANNELS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_buf(buf_v), .i_ready(ready),
      .o_valid(valid), .o_data(data), .o_row(row), .o_ch(ch), .o_last(last), .o_busy(busy),
      .o_peak_val(pk_val), .o_peak_idx(pk_idx), .o_done(done));

   pe_buf_drain #(.ROWS(ROWS), .CHANNELS(CHANNELS), .ACC_W(ACC_W), .OUT_W(OUT_W), .SHIFT(0)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_buf(buf0), .i_ready(ready0),
      .o_valid(valid0), .o_data(data0), .o_row(row0), .o_ch(ch0), .o_last(last0), .o_busy(busy0),
      .o_peak_val(pkv0), .o_peak_idx(pki0), .o_done(done0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input longint act, input longint exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
      end
   endtask

   // Reference requantizer in plain integer arithmetic.
   function automatic longint model_q(input longint e, input int sh);
      longint r;
      r = e;
      if (sh > 0) r = r + (longint'(1) << (sh - 1));
      r = r / (longint'(1) << sh);
      return (r > OMAX) ? OMAX : r;
   endfunction

   // Model state: 0 idle, 1 streaming, 2 done cycle.
   int m_phase = 0;
   int pos = 0;
   int vcnt = 0;
   int vcnt_obs = 0;
   int last_cnt = 0;
   int p0 = 0;
   longint m_pk_val = 0;
   longint m_pk_idx = 0;
   longint exp_q[N];
   longint obs_d[N];
   longint obs_r[N];
   longint obs_c[N];
   longint obs0[N];

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_valid", valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_data", data, 0);
         chk("rst_peak_val", pk_val, 0);
         chk("rst_peak_idx", pk_idx, 0);
         m_phase = 0; pos = 0; p0 = 0;
         m_pk_val = 0; m_pk_idx = 0;
      end else begin
         // SHIFT=0 instance: ready tied high, record its stream.
         if (valid0) begin
            if (p0 < N) obs0[p0] = data0;
            p0++;
         end
         if (done0) begin
            chk("s0_d0", obs0[0], 65535);
            chk("s0_d1_sat", obs0[1], 65535);
            chk("s0_d2_noround", obs0[2], 255);
            chk("s0_count", p0, N);
            p0 = 0;
         end
         case (m_phase)
            0: begin
               chk("idle_valid", valid, 0);
               chk("idle_busy", busy, 0);
               chk("idle_done", done, 0);
               chk("hold_peak_val", pk_val, m_pk_val);
               chk("hold_peak_idx", pk_idx, m_pk_idx);
               if (start) begin
                  for (int i = 0; i < N; i++) exp_q[i] = model_q(longint'(buf_v[i]), SHIFT);
                  m_phase = 1; pos = 0; vcnt = 0; vcnt_obs = 0; last_cnt = 0;
               end
            end
            1: begin
               vcnt++;
               if (valid) vcnt_obs++;
               if (last) last_cnt++;
               chk("valid", valid, 1);
               chk("busy", busy, 1);
               chk("done_early", done, 0);
               chk("data", data, exp_q[pos]);
               chk("row", row, pos / CHANNELS);
               chk("ch", ch, pos % CHANNELS);
               chk("last", last, (pos == N - 1) ? 1 : 0);
               if (ready) begin
                  obs_d[pos] = data; obs_r[pos] = row; obs_c[pos] = ch;
                  pos++;
                  if (pos == N) m_phase = 2;
               end
               if (vcnt > 100) begin
                  chk("drain_timeout", vcnt, 100);
                  m_phase = 0;
               end
            end
            default: begin
               chk("done_pulse", done, 1);
               chk("done_valid", valid, 0);
               chk("done_busy", busy, 1);
               m_pk_val = exp_q[0]; m_pk_idx = 0;
               for (int i = 1; i < N; i++)
                  if (exp_q[i] > m_pk_val) begin m_pk_val = exp_q[i]; m_pk_idx = i; end
               chk("peak_val", pk_val, m_pk_val);
               chk("peak_idx", pk_idx, m_pk_idx);
               chk("valid_cycles", vcnt_obs, lit_vcyc);
               chk("last_count", last_cnt, 1);
               case (lit_mode)
                  1: begin
                     chk("round_384", obs_d[0], 2);
                     chk("round_127", obs_d[1], 0);
                     chk("round_128", obs_d[2], 1);
                     chk("rc1_ch", obs_c[1], 1);
                     chk("rc2_ch", obs_c[2], 2);
                     chk("rc2_row", obs_r[2], 0);
                     chk("sat_2p24", obs_d[5], 65535);
                     chk("sat_full", obs_d[6], 65535);
                     chk("sat_round", obs_d[7], 65535);
                  end
                  2: begin
                     chk("bp_row4", obs_r[4], 1);
                     chk("bp_ch4", obs_c[4], 0);
                  end
                  3: begin
                     chk("tie_peak_val", pk_val, 9);
                     chk("tie_peak_idx", pk_idx, 10);
                  end
                  4: begin
                     chk("zero_peak_val", pk_val, 0);
                     chk("zero_peak_idx", pk_idx, 0);
                  end
                  default: ;
               endcase
               m_phase = 0;
            end
         endcase
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 150; k++) begin
         tick();
         if (done) break;
      end
      tick();
      tick();
   endtask

   task automatic fill_pattern();
      for (int i = 0; i < N; i++) buf_v[i] = ACC_W'((i + 1) * 1000);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; ready = 1'b1; ready0 = 1'b1;
      fill_pattern();
      for (int i = 0; i < N; i++) buf0[i] = '0;
      buf0[0] = ACC_W'(65535);
      buf0[1] = ACC_W'(65536);
      buf0[2] = ACC_W'(255);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Rounding, saturation and full-length drain.
      buf_v[0] = ACC_W'(384);
      buf_v[1] = ACC_W'(127);
      buf_v[2] = ACC_W'(128);
      buf_v[5] = ACC_W'(1) << 24;
      buf_v[6] = '1;
      buf_v[7] = ACC_W'(36'hFFFF80);
      lit_mode = 1; lit_vcyc = 32;
      start_pulse();
      wait_done();

      // Backpressure: three stall cycles on sample 4.
      fill_pattern();
      lit_mode = 2; lit_vcyc = 35;
      start_pulse();
      tick(); tick(); tick(); tick();
      ready = 1'b0;
      tick(); tick(); tick();
      ready = 1'b1;
      wait_done();

      // Peak with ties.
      for (int i = 0; i < N; i++) buf_v[i] = ACC_W'(100);
      buf_v[4] = ACC_W'(768);
      buf_v[10] = ACC_W'(2304);
      buf_v[20] = ACC_W'(2354);
      lit_mode = 3; lit_vcyc = 32;
      start_pulse();
      wait_done();

      // All-zero buffer.
      for (int i = 0; i < N; i++) buf_v[i] = '0;
      lit_mode = 4;
      start_pulse();
      wait_done();

      // Start while busy, then reset while sample 12 is presented.
      fill_pattern();
      lit_mode = 0;
      start_pulse();
      tick(); tick(); tick(); tick(); tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick(); tick(); tick(); tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();

      // Fresh drain from index 0, then start during the done cycle is ignored.
      for (int i = 0; i < N; i++) buf_v[i] = ACC_W'((N - i) * 700);
      lit_mode = 0; lit_vcyc = 32;
      start_pulse();
      for (int k = 0; k < 150; k++) begin
         tick();
         if (done) break;
      end
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
